// File: rtl/pwm_divfreq_multi.sv
// pwm_divfreq_multi: NB_CH independent divider/PWM channels sharing one
// clock, one run enable and one register write port. New period/on-time
// values are staged in pending registers and only become active at the
// channel's own period boundary (or straight away while disabled), so a
// running output never shows a shortened or stretched pulse.
module pwm_divfreq_multi #(
  parameter int unsigned NB_CH     = 4,
  parameter int unsigned BUS_SIZE  = 8,
  parameter int unsigned DEF_NBT   = 30,
  parameter int unsigned DEF_NBTON = 10,
  parameter logic        POLARITY  = 1'b1,
  localparam int unsigned CH_W     = (NB_CH > 1) ? $clog2(NB_CH) : 1
) (
  input  logic                ClkIn,
  input  logic                nReset,
  input  logic                Enable,
  input  logic                WrEn,
  input  logic [CH_W-1:0]     WrCh,
  input  logic                WrSel,
  input  logic [BUS_SIZE-1:0] WrData,
  output logic [NB_CH-1:0]    ClkOut,
  output logic [NB_CH-1:0]    PeriodTick,
  output logic [NB_CH-1:0]    Pending
);

  localparam logic [BUS_SIZE-1:0] DEF_PER = BUS_SIZE'(DEF_NBT);
  localparam logic [BUS_SIZE-1:0] DEF_TON = BUS_SIZE'(DEF_NBTON);
  localparam logic [CH_W:0]       NB_CH_L = (CH_W + 1)'(NB_CH);
  localparam logic                INACT   = ~POLARITY;

  // Per-channel counter plus active (in use) and pending (staged) settings
  logic [BUS_SIZE-1:0] r_cnt  [NB_CH];
  logic [BUS_SIZE-1:0] r_perA [NB_CH];
  logic [BUS_SIZE-1:0] r_tonA [NB_CH];
  logic [BUS_SIZE-1:0] r_perP [NB_CH];
  logic [BUS_SIZE-1:0] r_tonP [NB_CH];
  logic [NB_CH-1:0]    r_pending;
  logic [NB_CH-1:0]    r_clkOut;
  logic [NB_CH-1:0]    r_tick;

  logic                w_wrValid;
  logic [NB_CH-1:0]    w_wrHit;
  logic [NB_CH-1:0]    w_atWrap;
  logic [NB_CH-1:0]    w_commit;

  // Decode the shared write port into a one-hot channel select; writes to
  // channel numbers that do not exist are dropped here
  always_comb begin
    w_wrValid = WrEn && ({1'b0, WrCh} < NB_CH_L);
    w_wrHit   = '0;
    for (int i = 0; i < NB_CH; i++) begin
      if (w_wrValid && (WrCh == CH_W'(i))) begin
        w_wrHit[i] = 1'b1;
      end
    end
  end

  // A staged value is committed at the wrap edge, or at once while disabled
  always_comb begin
    w_atWrap = '0;
    w_commit = '0;
    for (int i = 0; i < NB_CH; i++) begin
      w_atWrap[i] = (r_cnt[i] == r_perA[i]);
      w_commit[i] = r_pending[i] && (!Enable || w_atWrap[i]);
    end
  end

  // Pending registers: a write always lands here; a same-edge commit has
  // already taken the old staged value, so the flag stays set for the new one
  always_ff @(posedge ClkIn or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < NB_CH; i++) begin
        r_perP[i] <= DEF_PER;
        r_tonP[i] <= DEF_TON;
      end
      r_pending <= '0;
    end else begin
      for (int i = 0; i < NB_CH; i++) begin
        if (w_wrHit[i]) begin
          if (WrSel) begin
            r_tonP[i] <= WrData;
          end else begin
            r_perP[i] <= WrData;
          end
          r_pending[i] <= 1'b1;
        end else if (w_commit[i]) begin
          r_pending[i] <= 1'b0;
        end
      end
    end
  end

  // Active registers: copy both staged fields together so period and
  // on-time of a channel always change on the same edge
  always_ff @(posedge ClkIn or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < NB_CH; i++) begin
        r_perA[i] <= DEF_PER;
        r_tonA[i] <= DEF_TON;
      end
    end else begin
      for (int i = 0; i < NB_CH; i++) begin
        if (w_commit[i]) begin
          r_perA[i] <= r_perP[i];
          r_tonA[i] <= r_tonP[i];
        end
      end
    end
  end

  // Period counters: wrap on reaching (or exceeding, after a lowered period)
  // the active period; held at zero while disabled so channels restart aligned
  always_ff @(posedge ClkIn or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < NB_CH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NB_CH; i++) begin
        if (!Enable) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] < r_perA[i]) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  // Registered outputs, decoded from the pre-edge count and active settings
  always_ff @(posedge ClkIn or negedge nReset) begin
    if (!nReset) begin
      r_clkOut <= {NB_CH{INACT}};
      r_tick   <= '0;
    end else begin
      for (int i = 0; i < NB_CH; i++) begin
        if (!Enable) begin
          r_clkOut[i] <= INACT;
          r_tick[i]   <= 1'b0;
        end else begin
          r_clkOut[i] <= (r_cnt[i] < r_tonA[i]) ? POLARITY : INACT;
          r_tick[i]   <= w_atWrap[i];
        end
      end
    end
  end

  assign ClkOut     = r_clkOut;
  assign PeriodTick = r_tick;
  assign Pending    = r_pending;

endmodule

// File: tb/tb_pwm_divfreq_multi.sv
// Bench for pwm_divfreq_multi: a cycle model of the channels predicts each
// edge's outputs into a queue, popped after the edge; scenario tasks add
// directed checks against fixed numbers (duty counts, tick positions).
module tb_pwm_divfreq_multi;

  logic       ClkIn = 1'b0;
  logic       nReset;
  logic       Enable;
  logic       WrEn;
  logic [1:0] WrCh;
  logic       WrSel;
  logic [7:0] WrData;
  logic [3:0] ClkOut;
  logic [3:0] PeriodTick;
  logic [3:0] Pending;
  logic [2:0] d3Clk;
  logic [2:0] d3Tick;
  logic [2:0] d3Pend;

  int total = 0;
  int bad   = 0;
  int cycle = 0;

  typedef struct packed {
    logic [3:0] clk;
    logic [3:0] tick;
    logic [3:0] pend;
  } exp_t;

  exp_t sbQ[$];

  int m_cnt [4];
  int m_perA[4];
  int m_tonA[4];
  int m_perP[4];
  int m_tonP[4];
  bit m_pend[4];
  bit m_clk [4];
  bit m_tick[4];

  logic [3:0] lastClk;
  logic [3:0] lastTick;
  logic [3:0] lastPend;

  pwm_divfreq_multi u_dut (
    .ClkIn(ClkIn), .nReset(nReset), .Enable(Enable), .WrEn(WrEn),
    .WrCh(WrCh), .WrSel(WrSel), .WrData(WrData),
    .ClkOut(ClkOut), .PeriodTick(PeriodTick), .Pending(Pending)
  );

  pwm_divfreq_multi #(.NB_CH(3)) u_dut3 (
    .ClkIn(ClkIn), .nReset(nReset), .Enable(Enable), .WrEn(WrEn),
    .WrCh(WrCh), .WrSel(WrSel), .WrData(WrData),
    .ClkOut(d3Clk), .PeriodTick(d3Tick), .Pending(d3Pend)
  );

  always #5 ClkIn = ~ClkIn;

  // Hard stop if anything ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog");
  end

  task automatic modelReset();
    for (int i = 0; i < 4; i++) begin
      m_cnt[i]  = 0;
      m_perA[i] = 30; m_perP[i] = 30;
      m_tonA[i] = 10; m_tonP[i] = 10;
      m_pend[i] = 0;  m_clk[i]  = 0; m_tick[i] = 0;
    end
    sbQ.delete();
  endtask

  // One clock: predict from current inputs, push, clock, pop and compare
  task automatic applyStimulus();
    exp_t e;
    exp_t got;
    for (int i = 0; i < 4; i++) begin
      bit hit;
      bit commit;
      int oldCnt;
      int oldPer;
      int oldTon;
      hit    = WrEn && (int'(WrCh) == i);
      commit = m_pend[i] && (!Enable || (m_cnt[i] == m_perA[i]));
      oldCnt = m_cnt[i];
      oldPer = m_perA[i];
      oldTon = m_tonA[i];
      if (Enable) begin
        m_clk[i]  = (oldCnt < oldTon);
        m_tick[i] = (oldCnt == oldPer);
        m_cnt[i]  = (oldCnt >= oldPer) ? 0 : oldCnt + 1;
      end else begin
        m_clk[i]  = 0;
        m_tick[i] = 0;
        m_cnt[i]  = 0;
      end
      if (commit) begin
        m_perA[i] = m_perP[i];
        m_tonA[i] = m_tonP[i];
        m_pend[i] = 0;
      end
      if (hit) begin
        if (WrSel) m_tonP[i] = int'(WrData);
        else       m_perP[i] = int'(WrData);
        m_pend[i] = 1;
      end
      e.clk[i]  = m_clk[i];
      e.tick[i] = m_tick[i];
      e.pend[i] = m_pend[i];
    end
    sbQ.push_back(e);
    @(posedge ClkIn);
    #1;
    cycle++;
    e = sbQ.pop_front();
    got.clk  = ClkOut;
    got.tick = PeriodTick;
    got.pend = Pending;
    lastClk  = ClkOut;
    lastTick = PeriodTick;
    lastPend = Pending;
    total += 3;
    if (got.clk !== e.clk) begin
      bad++;
      $display("[TB] FAIL sb_clkout cycle=%0d got=%b exp=%b", cycle, got.clk, e.clk);
    end
    if (got.tick !== e.tick) begin
      bad++;
      $display("[TB] FAIL sb_tick cycle=%0d got=%b exp=%b", cycle, got.tick, e.tick);
    end
    if (got.pend !== e.pend) begin
      bad++;
      $display("[TB] FAIL sb_pending cycle=%0d got=%b exp=%b", cycle, got.pend, e.pend);
    end
  endtask

  task automatic doReset(input logic en);
    @(negedge ClkIn);
    nReset = 1'b0;
    Enable = 1'b0;
    WrEn   = 1'b0;
    modelReset();
    @(negedge ClkIn);
    nReset = 1'b1;
    Enable = en;
  endtask

  task automatic doWrite(input logic [1:0] ch, input logic sel, input logic [7:0] data);
    WrCh   = ch;
    WrSel  = sel;
    WrData = data;
    WrEn   = 1'b1;
    applyStimulus();
    WrEn   = 1'b0;
  endtask

  task automatic waitClear(input int ch, input string name);
    int n = 0;
    while (lastPend[ch] && n < 80) begin
      applyStimulus();
      n++;
    end
    total++;
    if (lastPend[ch] !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s pending never cleared got=%b exp=0", name, lastPend[ch]);
    end
  endtask

  task automatic test_reset();
    int hi0 = 0;
    int hiAll = 0;
    int ticks = 0;
    int firstTick = -1;
    $display("[TB] test_reset");
    #12;
    total += 3;
    if (ClkOut !== 4'b0000) begin bad++; $display("[TB] FAIL rst_clkout got=%b exp=0000", ClkOut); end
    if (PeriodTick !== 4'b0000) begin bad++; $display("[TB] FAIL rst_tick got=%b exp=0000", PeriodTick); end
    if (Pending !== 4'b0000) begin bad++; $display("[TB] FAIL rst_pending got=%b exp=0000", Pending); end
    doReset(1'b1);
    for (int k = 0; k < 62; k++) begin
      applyStimulus();
      if (k < 31 && lastClk[0]) hi0++;
      if (k < 31 && lastClk == 4'b1111) hiAll++;
      if (lastTick[0]) begin
        ticks++;
        if (firstTick < 0) firstTick = k;
      end
    end
    total += 4;
    if (hi0 !== 10) begin bad++; $display("[TB] FAIL rst_high_count got=%0d exp=10", hi0); end
    if (hiAll !== 10) begin bad++; $display("[TB] FAIL rst_all_high got=%0d exp=10", hiAll); end
    if (ticks !== 2) begin bad++; $display("[TB] FAIL rst_tick_count got=%0d exp=2", ticks); end
    if (firstTick !== 30) begin bad++; $display("[TB] FAIL rst_tick_pos got=%0d exp=30", firstTick); end
  endtask

  task automatic test_glitch_free();
    int hi1 = 0;
    int hi0 = 0;
    int tk1 = 0;
    $display("[TB] test_glitch_free");
    doReset(1'b1);
    repeat (5) applyStimulus();
    doWrite(2'd1, 1'b0, 8'd9);
    doWrite(2'd1, 1'b1, 8'd3);
    total++;
    if (lastPend !== 4'b0010) begin bad++; $display("[TB] FAIL gf_pending got=%b exp=0010", lastPend); end
    waitClear(1, "gf_commit");
    total++;
    if (lastTick !== 4'b1111) begin bad++; $display("[TB] FAIL gf_commit_at_wrap got=%b exp=1111", lastTick); end
    for (int k = 0; k < 10; k++) begin
      applyStimulus();
      if (lastClk[1]) hi1++;
      if (lastClk[0]) hi0++;
      if (lastTick[1]) tk1++;
    end
    total += 4;
    if (hi1 !== 3) begin bad++; $display("[TB] FAIL gf_ch1_high got=%0d exp=3", hi1); end
    if (tk1 !== 1) begin bad++; $display("[TB] FAIL gf_ch1_ticks got=%0d exp=1", tk1); end
    if (lastTick[1] !== 1'b1) begin bad++; $display("[TB] FAIL gf_ch1_tick_pos got=%b exp=1", lastTick[1]); end
    if (hi0 !== 10) begin bad++; $display("[TB] FAIL gf_ch0_high got=%0d exp=10", hi0); end
  endtask

  task automatic test_wrap_collision();
    int n = 0;
    int hi2 = 0;
    $display("[TB] test_wrap_collision");
    doReset(1'b1);
    repeat (3) applyStimulus();
    doWrite(2'd2, 1'b1, 8'd7);
    while (m_cnt[2] != m_perA[2] && n < 40) begin
      applyStimulus();
      n++;
    end
    doWrite(2'd2, 1'b1, 8'd20);
    total += 2;
    if (lastPend[2] !== 1'b1) begin bad++; $display("[TB] FAIL wc_pending_kept got=%b exp=1", lastPend[2]); end
    if (lastTick[2] !== 1'b1) begin bad++; $display("[TB] FAIL wc_on_wrap got=%b exp=1", lastTick[2]); end
    for (int k = 0; k < 31; k++) begin
      applyStimulus();
      if (lastClk[2]) hi2++;
    end
    total += 2;
    if (hi2 !== 7) begin bad++; $display("[TB] FAIL wc_old_value_high got=%0d exp=7", hi2); end
    if (lastPend[2] !== 1'b0) begin bad++; $display("[TB] FAIL wc_second_commit got=%b exp=0", lastPend[2]); end
    hi2 = 0;
    for (int k = 0; k < 31; k++) begin
      applyStimulus();
      if (lastClk[2]) hi2++;
    end
    total++;
    if (hi2 !== 20) begin bad++; $display("[TB] FAIL wc_new_value_high got=%0d exp=20", hi2); end
  endtask

  task automatic test_extremes();
    int hi0;
    int tk0;
    $display("[TB] test_extremes");
    doReset(1'b1);
    doWrite(2'd0, 1'b1, 8'd0);
    waitClear(0, "ex_ton0");
    hi0 = 0;
    for (int k = 0; k < 31; k++) begin applyStimulus(); if (lastClk[0]) hi0++; end
    total++;
    if (hi0 !== 0) begin bad++; $display("[TB] FAIL ex_ton0_high got=%0d exp=0", hi0); end
    doWrite(2'd0, 1'b1, 8'd255);
    waitClear(0, "ex_ton255");
    hi0 = 0;
    for (int k = 0; k < 31; k++) begin applyStimulus(); if (lastClk[0]) hi0++; end
    total++;
    if (hi0 !== 31) begin bad++; $display("[TB] FAIL ex_ton255_high got=%0d exp=31", hi0); end
    doWrite(2'd0, 1'b0, 8'd0);
    doWrite(2'd0, 1'b1, 8'd1);
    waitClear(0, "ex_per0");
    hi0 = 0; tk0 = 0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus();
      if (lastClk[0]) hi0++;
      if (lastTick[0]) tk0++;
    end
    total += 2;
    if (hi0 !== 8) begin bad++; $display("[TB] FAIL ex_per0_high got=%0d exp=8", hi0); end
    if (tk0 !== 8) begin bad++; $display("[TB] FAIL ex_per0_ticks got=%0d exp=8", tk0); end
    doWrite(2'd0, 1'b0, 8'd4);
    doWrite(2'd0, 1'b1, 8'd4);
    waitClear(0, "ex_ton_eq_per");
    hi0 = 0; tk0 = 0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus();
      if (lastClk[0]) hi0++;
      if (lastTick[0]) tk0++;
    end
    total += 2;
    if (hi0 !== 4) begin bad++; $display("[TB] FAIL ex_eq_high got=%0d exp=4", hi0); end
    if (tk0 !== 1) begin bad++; $display("[TB] FAIL ex_eq_ticks got=%0d exp=1", tk0); end
  endtask

  task automatic test_enable_gating();
    $display("[TB] test_enable_gating");
    doReset(1'b1);
    repeat (7) applyStimulus();
    doWrite(2'd3, 1'b0, 8'd15);
    repeat (3) applyStimulus();
    Enable = 1'b0;
    applyStimulus();
    total += 3;
    if (lastClk !== 4'b0000) begin bad++; $display("[TB] FAIL en_off_clkout got=%b exp=0000", lastClk); end
    if (lastTick !== 4'b0000) begin bad++; $display("[TB] FAIL en_off_tick got=%b exp=0000", lastTick); end
    if (lastPend !== 4'b0000) begin bad++; $display("[TB] FAIL en_off_commit got=%b exp=0000", lastPend); end
    repeat (2) applyStimulus();
    Enable = 1'b1;
    applyStimulus();
    total++;
    if (lastClk !== 4'b1111) begin bad++; $display("[TB] FAIL en_on_aligned got=%b exp=1111", lastClk); end
    repeat (15) applyStimulus();
    total++;
    if (lastTick !== 4'b1000) begin bad++; $display("[TB] FAIL en_ch3_period16 got=%b exp=1000", lastTick); end
  endtask

  task automatic test_async_reset();
    int hiMain = 0;
    int hi3 = 0;
    int tk3 = 0;
    $display("[TB] test_async_reset");
    doReset(1'b1);
    doWrite(2'd1, 1'b1, 8'd2);
    repeat (3) applyStimulus();
    total++;
    if (lastClk[0] !== 1'b1) begin bad++; $display("[TB] FAIL ar_pre_high got=%b exp=1", lastClk[0]); end
    #2;
    nReset = 1'b0;
    #1;
    total += 3;
    if (ClkOut !== 4'b0000) begin bad++; $display("[TB] FAIL ar_clkout_async got=%b exp=0000", ClkOut); end
    if (Pending !== 4'b0000) begin bad++; $display("[TB] FAIL ar_pending got=%b exp=0000", Pending); end
    if (PeriodTick !== 4'b0000) begin bad++; $display("[TB] FAIL ar_tick got=%b exp=0000", PeriodTick); end
    modelReset();
    @(negedge ClkIn);
    nReset = 1'b1;
    Enable = 1'b1;
    doWrite(2'd3, 1'b0, 8'd0);
    if (lastClk[0]) hiMain++;
    if (d3Clk[0]) hi3++;
    total += 2;
    if (d3Pend !== 3'b000) begin bad++; $display("[TB] FAIL ar_oob_ignored got=%b exp=000", d3Pend); end
    if (lastPend !== 4'b1000) begin bad++; $display("[TB] FAIL ar_inrange_write got=%b exp=1000", lastPend); end
    for (int k = 0; k < 30; k++) begin
      applyStimulus();
      if (lastClk[0]) hiMain++;
      if (d3Clk[0]) hi3++;
      if (d3Tick[0]) tk3++;
    end
    total += 3;
    if (hiMain !== 10) begin bad++; $display("[TB] FAIL ar_default_high got=%0d exp=10", hiMain); end
    if (hi3 !== 10) begin bad++; $display("[TB] FAIL ar_dut3_high got=%0d exp=10", hi3); end
    if (tk3 !== 1) begin bad++; $display("[TB] FAIL ar_dut3_ticks got=%0d exp=1", tk3); end
  endtask

  initial begin
    nReset = 1'b0;
    Enable = 1'b0;
    WrEn   = 1'b0;
    WrCh   = '0;
    WrSel  = 1'b0;
    WrData = '0;
    lastClk = '0; lastTick = '0; lastPend = '0;
    modelReset();
    test_reset();
    test_glitch_free();
    test_wrap_collision();
    test_extremes();
    test_enable_gating();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_divfreq_multi.md
Name: pwm_divfreq_multi

Overview:
- Multi-channel successor to the single-channel fixed divider.
- NB_CH independent divider/PWM channels, each with a period and on-time that are programmable at run time.
- Writes land in a pending register and are committed only at that channel's period boundary, so the output never glitches.
- Sits between the control register bus and the clock/PWM consumers (LEDs, motor drivers, sampling strobes).

Parameters:
- NB_CH, 4, number of channels (1..16).
- BUS_SIZE, 8, width of the counter, period and on-time registers.
- DEF_NBT, 30, reset value of the period register for all channels (period = NBT+1 cycles).
- DEF_NBTON, 10, reset value of the on-time register for all channels.
- POLARITY, 1, active output level. The inactive level is ~POLARITY.

Ports:
- ClkIn  in  1  single clock. All logic is rising-edge.
- nReset  in  1  asynchronous, active-low reset.
- Enable  in  1  global run enable.
- WrEn  in  1  write strobe, sampled on the rising edge.
- WrCh  in  CH_W=max(1,$clog2(NB_CH))  target channel.
- WrSel  in  1  0 = period (NBT), 1 = on-time (NBTON).
- WrData  in  BUS_SIZE  value to write.
- ClkOut  out  NB_CH  per-channel divided/PWM output, registered.
- PeriodTick  out  NB_CH  one-cycle pulse per channel at end of period, registered.
- Pending  out  NB_CH  per-channel flag: a written value is waiting for commit.

Behaviour:
- Per-channel state:
  - Cnt[i]: BUS_SIZE bits.
  - Active registers: PerA[i], TonA[i].
  - Pending registers: PerP[i], TonP[i].
  - Pending flag: Pending[i].
- Reset (nReset=0, asynchronous, any time, including mid-period or mid-write):
  - Cnt=0.
  - PerA=PerP=DEF_NBT, TonA=TonP=DEF_NBTON.
  - Pending=0, ClkOut=~POLARITY (all bits), PeriodTick=0.
  - Release is synchronous to the next rising edge.
- Write:
  - WrEn=1 and WrCh<NB_CH: at the edge, PerP or TonP of channel WrCh <= WrData, and Pending[WrCh] <= 1.
  - WrCh>=NB_CH: write ignored, no flag change.
  - Only one channel/field is written per cycle.
- Commit: channel i copies PerP->PerA and TonP->TonA, and clears Pending[i], at any edge where Pending[i]=1 and either:
  - Enable=0, or
  - Enable=1 and Cnt[i]==PerA[i] (wrap edge).
- Write and commit in the same cycle, same channel:
  - The commit uses the pre-edge PerP/TonP values.
  - The new WrData lands in the pending register.
  - Pending[i] stays 1; the new value commits at the next boundary.
- Counting (Enable=1), with PerA as the pre-edge value: Cnt[i] <= (Cnt[i] < PerA[i]) ? Cnt[i]+1 : 0.
  - If PerA is lowered below the current Cnt by a commit, the next edge wraps to 0. No counting past PerA.
  - The counter never exceeds 2^BUS_SIZE-1. No overflow is possible because compare is with >=.
- Output (Enable=1), one-cycle registered latency from Cnt:
  - ClkOut[i] <= (Cnt[i] < TonA[i]) ? POLARITY : ~POLARITY, using pre-edge Cnt/TonA.
  - PeriodTick[i] <= (Cnt[i]==PerA[i]).
- Disabled (Enable=0):
  - All Cnt <= 0, ClkOut <= ~POLARITY, PeriodTick <= 0.
  - Pending commits happen immediately.
  - On Enable 0->1, all channels start from Cnt=0 together; the first active ClkOut level appears one edge after Enable is sampled high.
- Boundary values:
  - TonA=0: output always inactive.
  - TonA>PerA: output always active.
  - TonA==PerA: output inactive for exactly 1 of PerA+1 cycles.
  - PerA=0: period is 1 cycle, PeriodTick stuck high while enabled, ClkOut active iff TonA>=1.
- Duty cycle = TonA/(PerA+1). Output frequency = f(ClkIn)/(PerA+1).
- Channels are fully independent except for the shared Enable and write port.

Test Plan:
- Reset defaults: hold nReset=0, then release with Enable=1, POLARITY=1 -> every ClkOut shows 10 cycles high, 21 low, repeating every 31 cycles; PeriodTick pulses once per 31 cycles, aligned with the last low cycle.
- Glitch-free update: channel 1 running defaults; at Cnt=5 write NBT=9 then NBTON=3 -> Pending[1]=1 until the Cnt==30 wrap edge; then the period is 10 with 3 high; channels 0, 2 and 3 are unchanged.
- Write colliding with the wrap: write NBTON=20 to channel 2 on exactly the edge where Cnt==PerA -> the old pending value commits, Pending[2] stays 1, and 20 takes effect one full period later.
- Extremes on channel 0: NBTON=0 -> constant low. NBTON=255 -> constant high. NBT=0, NBTON=1 -> constant high with PeriodTick constant high. NBTON==NBT=4 -> 4 high, 1 low.
- Enable gating: drop Enable mid-period -> next edge all ClkOut=0, Cnt=0, and a pending write commits with Pending cleared; raise Enable -> all channels restart phase-aligned.
- Asynchronous reset mid-operation: assert nReset between clock edges during an active-high phase -> ClkOut goes to 0 immediately, with no clock needed; Pending=0; defaults (30/10) restored; WrCh=NB_CH write ignored.
